// File: rtl/mips_byte_fetch_unit_if.sv
// Fetch unit bus bundle: byte-wide program memory port, decode handshake,
// redirect request and stall counter readout.
interface mips_byte_fetch_unit_if;
    logic [7:0]  address_out;
    logic [7:0]  data_in;
    logic [31:0] instr;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [15:0] perf_stall_cnt;

    modport master (
        output address_out,
        input  data_in,
        output instr,
        output instr_pc,
        output instr_valid,
        input  instr_ready,
        input  redirect,
        input  redirect_pc,
        output perf_stall_cnt
    );

    modport slave (
        input  address_out,
        output data_in,
        input  instr,
        input  instr_pc,
        input  instr_valid,
        output instr_ready,
        output redirect,
        output redirect_pc,
        input  perf_stall_cnt
    );
endinterface

// File: rtl/mips_byte_fetch_unit.sv
// Byte-serial instruction fetch: issues 4 bytes per word, assembles big-endian,
// buffers words in a DEPTH-entry FIFO. Stall counter built only with FETCH_PERF_CNT_EN.
//
// state    | meaning
// ISSUE_B0 | next issue is byte 0 of a word; waits for a free credit
// ISSUE_B1 | byte 1 issues unconditionally this cycle
// ISSUE_B2 | byte 2 issues unconditionally this cycle
// ISSUE_B3 | byte 3 issues unconditionally this cycle
module mips_byte_fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00,
    parameter int         DEPTH    = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    mips_byte_fetch_unit_if.master  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {ISSUE_B0, ISSUE_B1, ISSUE_B2, ISSUE_B3} state_t;

    state_t             state_q, state_d;
    logic [7:0]         pc_q, pc_d;
    logic               inflight_q, inflight_d;
    logic [1:0]         inflight_idx_q, inflight_idx_d;
    logic [7:0]         inflight_pc_q, inflight_pc_d;
    logic [31:0]        asm_q, asm_d;
    logic [7:0]         asm_pc_q, asm_pc_d;
    logic [1:0]         started_q, started_d;
    logic [39:0]        fifo_mem_q [DEPTH];
    logic [39:0]        fifo_mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic        pop, push, credit_ok, issue, issue_b0;
    logic [3:0]  credits;
    logic [39:0] push_entry;

    // A pop releases its credit in the same cycle, so byte 0 can go out right away.
    assign pop        = (count_q != '0) && bus.instr_ready;
    assign credits    = 4'(count_q) + 4'(started_q) - 4'(pop);
    assign credit_ok  = credits < 4'(DEPTH);
    assign push       = inflight_q && (inflight_idx_q == 2'd3);
    assign push_entry = {asm_q[31:8], bus.data_in, asm_pc_q};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ISSUE_B0;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (bus.redirect) begin
            state_d = ISSUE_B0;
        end else begin
            case (state_q)
                ISSUE_B0: if (credit_ok) state_d = ISSUE_B1;
                ISSUE_B1: state_d = ISSUE_B2;
                ISSUE_B2: state_d = ISSUE_B3;
                default:  state_d = ISSUE_B0;
            endcase
        end
    end

    always_comb begin
        issue    = 1'b1;
        issue_b0 = 1'b0;
        case (state_q)
            ISSUE_B0: begin
                issue    = credit_ok;
                issue_b0 = credit_ok;
            end
            default: ;
        endcase
    end

    always_comb begin
        pc_d           = pc_q;
        inflight_d     = 1'b0;
        inflight_idx_d = inflight_idx_q;
        inflight_pc_d  = inflight_pc_q;
        asm_d          = asm_q;
        asm_pc_d       = asm_pc_q;
        fifo_mem_d     = fifo_mem_q;
        wr_ptr_d       = wr_ptr_q + PTR_W'(push);
        rd_ptr_d       = rd_ptr_q + PTR_W'(pop);
        count_d        = count_q + CNT_W'(push) - CNT_W'(pop);
        started_d      = started_q + {1'b0, issue_b0} - {1'b0, push};

        if (issue) begin
            pc_d           = pc_q + 8'd1;
            inflight_d     = 1'b1;
            inflight_idx_d = 2'(state_q);
            inflight_pc_d  = pc_q;
        end

        if (inflight_q) begin
            case (inflight_idx_q)
                2'd0: begin
                    asm_d[31:24] = bus.data_in;
                    asm_pc_d     = inflight_pc_q;
                end
                2'd1: asm_d[23:16] = bus.data_in;
                2'd2: asm_d[15:8]  = bus.data_in;
                default: asm_d[7:0] = bus.data_in;
            endcase
        end
        if (push) fifo_mem_d[wr_ptr_q] = push_entry;

        // The byte returning next cycle belongs to the abandoned stream.
        if (bus.redirect) begin
            pc_d       = {bus.redirect_pc[7:2], 2'b00};
            inflight_d = 1'b0;
            asm_d      = '0;
            asm_pc_d   = '0;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            started_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q           <= RESET_PC;
            inflight_q     <= 1'b0;
            inflight_idx_q <= 2'd0;
            inflight_pc_q  <= 8'h00;
            asm_q          <= '0;
            asm_pc_q       <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            started_q      <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_mem_q[i] <= '0;
        end else begin
            pc_q           <= pc_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
            inflight_pc_q  <= inflight_pc_d;
            asm_q          <= asm_d;
            asm_pc_q       <= asm_pc_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            started_q      <= started_d;
            fifo_mem_q     <= fifo_mem_d;
        end
    end

    assign bus.address_out = pc_q;
    assign bus.instr_valid = (count_q != '0);
    assign bus.instr       = bus.instr_valid ? fifo_mem_q[rd_ptr_q][39:8] : 32'h0;
    assign bus.instr_pc    = bus.instr_valid ? fifo_mem_q[rd_ptr_q][7:0]  : 8'h00;

`ifdef FETCH_PERF_CNT_EN
    logic [15:0] perf_q, perf_d;

    // Survives redirect on purpose: only reset clears it.
    always_comb begin
        perf_d = perf_q;
        if ((state_q == ISSUE_B0) && !credit_ok && (perf_q != 16'hFFFF))
            perf_d = perf_q + 16'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) perf_q <= 16'h0000;
        else     perf_q <= perf_d;
    end

    assign bus.perf_stall_cnt = perf_q;
`else
    assign bus.perf_stall_cnt = 16'h0000;
`endif
endmodule

// File: tb/tb_mips_byte_fetch_unit.sv
// Directed bench for mips_byte_fetch_unit; memory returns addr ^ 8'hA5.
module tb_mips_byte_fetch_unit;
`ifdef FETCH_PERF_CNT_EN
    localparam bit PERF_EN = 1'b1;
`else
    localparam bit PERF_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_vec = 0;
    int   n_err = 0;

    mips_byte_fetch_unit_if bus_if ();

    mips_byte_fetch_unit #(.RESET_PC(8'h00), .DEPTH(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus_if.data_in <= bus_if.address_out ^ 8'hA5;

    task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            @(negedge clk);
        end
    endtask

    task automatic check_word(input string tag, input logic [7:0] pc, input logic [31:0] word);
        check({tag, "_valid"}, 40'(bus_if.instr_valid), 40'h1);
        check({tag, "_pc"},    40'(bus_if.instr_pc),    40'(pc));
        check({tag, "_instr"}, 40'(bus_if.instr),       40'(word));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr"},  40'(bus_if.address_out),    40'h00);
        check({tag, "_valid"}, 40'(bus_if.instr_valid),    40'h0);
        check({tag, "_instr"}, 40'(bus_if.instr),          40'h0);
        check({tag, "_pc"},    40'(bus_if.instr_pc),       40'h00);
        check({tag, "_perf"},  40'(bus_if.perf_stall_cnt), 40'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, want finish");
        $fatal(1);
    end

    initial begin
        int guard;
        rst                  = 1'b1;
        bus_if.instr_ready   = 1'b1;
        bus_if.redirect      = 1'b0;
        bus_if.redirect_pc   = 8'h00;
        step(2);
        check_reset_outputs("rst0");

        // free run, ready high
        rst = 1'b0;
        check("fr_addr0", 40'(bus_if.address_out), 40'h00);
        for (int k = 1; k <= 4; k++) begin
            step(1);
            check($sformatf("fr_addr%0d", k), 40'(bus_if.address_out), 40'(k));
        end
        check("fr_c4_valid", 40'(bus_if.instr_valid), 40'h0);
        step(1);
        check_word("fr_c5", 8'h00, 32'hA5A4A7A6);
        step(1);
        check("fr_c6_valid", 40'(bus_if.instr_valid), 40'h0);
        step(3);
        check_word("fr_c9", 8'h04, 32'hA1A0A3A2);

        // stall with ready low until FIFO full
        rst = 1'b1;
        bus_if.instr_ready = 1'b0;
        step(1);
        rst = 1'b0;
        step(12);
        check("st_park_addr", 40'(bus_if.address_out), 40'h08);
        check_word("st_c12", 8'h00, 32'hA5A4A7A6);
        step(16);
        check("st_c28_addr", 40'(bus_if.address_out), 40'h08);
        check("st_c28_instr", 40'(bus_if.instr), 40'hA5A4A7A6);
        check("st_c28_perf", 40'(bus_if.perf_stall_cnt), PERF_EN ? 40'd20 : 40'd0);
        bus_if.instr_ready = 1'b1;
        step(1);
        check("st_c29_addr", 40'(bus_if.address_out), 40'h09);
        check_word("st_c29", 8'h04, 32'hA1A0A3A2);
        check("st_c29_perf", 40'(bus_if.perf_stall_cnt), PERF_EN ? 40'd20 : 40'd0);
        step(1);
        check("st_c30_valid", 40'(bus_if.instr_valid), 40'h0);
        step(3);
        check_word("st_c33", 8'h08, 32'hADACAFAE);

        // redirect to 0x47 while byte 2 of pc 0x10 issues, FIFO holding pc 0x0C
        guard = 0;
        while (bus_if.address_out !== 8'h10 && guard < 64) begin
            step(1);
            guard++;
        end
        check("rd_wait_pc10", 40'(bus_if.address_out), 40'h10);
        bus_if.instr_ready = 1'b0;
        step(2);
        check("rd_pre_addr", 40'(bus_if.address_out), 40'h12);
        check_word("rd_pre", 8'h0C, 32'hA9A8ABAA);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 8'h47;
        step(1);
        bus_if.redirect    = 1'b0;
        bus_if.instr_ready = 1'b1;
        check("rd_addr", 40'(bus_if.address_out), 40'h44);
        check("rd_flush_valid", 40'(bus_if.instr_valid), 40'h0);
        step(5);
        check_word("rd_word", 8'h44, 32'hE1E0E3E2);
        check("rd_perf_kept", 40'(bus_if.perf_stall_cnt), PERF_EN ? 40'd20 : 40'd0);

        // redirect near top of memory, low bits ignored
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 8'hFE;
        step(1);
        bus_if.redirect = 1'b0;
        check("wr_addr_fc", 40'(bus_if.address_out), 40'hFC);
        step(3);
        check("wr_addr_ff", 40'(bus_if.address_out), 40'hFF);
        step(1);
        check("wr_addr_00", 40'(bus_if.address_out), 40'h00);
        step(1);
        check_word("wr_fc", 8'hFC, 32'h59585B5A);
        step(4);
        check_word("wr_00", 8'h00, 32'hA5A4A7A6);

        // async reset mid-word with credits exhausted and a redirect pending
        bus_if.instr_ready = 1'b0;
        step(2);
        check("ar_pre_addr", 40'(bus_if.address_out), 40'h07);
        bus_if.redirect    = 1'b1;
        bus_if.redirect_pc = 8'h80;
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("ar_async");
        @(negedge clk);
        rst                = 1'b0;
        bus_if.redirect    = 1'b0;
        bus_if.instr_ready = 1'b1;
        check("ar_restart_addr", 40'(bus_if.address_out), 40'h00);
        step(5);
        check_word("ar_word", 8'h00, 32'hA5A4A7A6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
